// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//    Shares one AXIS-to-UART transmitter between NUM_SRC AXI-Stream byte
//    sources. Only one source is granted at a time. A grant is held until the
//    source ends its packet (tlast), has sent MAX_BURST bytes, or has kept
//    tvalid low for STALL_TIMEOUT cycles. Sources are served round-robin, so
//    the source released last has the lowest priority next. Accepted bytes
//    pass through a registered one-entry output stage that feeds the
//    transmitter's AXIS slave at full throughput.
//
// Parameters:
//    NUM_SRC        number of requesting sources (2..8)
//    MAX_BURST      bytes per grant before a forced release (>= 1)
//    STALL_TIMEOUT  idle cycles a granted source may keep tvalid low (>= 2)
//
// Ports:
//    clk          in   system clock
//    reset        in   asynchronous, active-high reset
//    in_tdata     in   source i byte at bits [8i+7:8i]
//    in_tvalid    in   per-source valid
//    in_tlast     in   per-source end of packet
//    in_tready    out  per-source ready (combinational, granted source only)
//    out_tdata    out  byte to the UART transmitter (registered)
//    out_tvalid   out  output valid (registered)
//    out_tready   in   transmitter ready
//    grant        out  one-hot current grant, zero when idle (registered)
//    busy         out  high while a source holds the grant
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_SRC       = 4,
   parameter int MAX_BURST     = 16,
   parameter int STALL_TIMEOUT = 256
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [8*NUM_SRC-1:0]   in_tdata,
   input  logic [NUM_SRC-1:0]     in_tvalid,
   input  logic [NUM_SRC-1:0]     in_tlast,
   output logic [NUM_SRC-1:0]     in_tready,
   output logic [7:0]             out_tdata,
   output logic                   out_tvalid,
   input  logic                   out_tready,
   output logic [NUM_SRC-1:0]     grant,
   output logic                   busy
);

   localparam int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int BEAT_W  = $clog2(MAX_BURST + 1);
   localparam int STALL_W = $clog2(STALL_TIMEOUT);

   // Counter values at which the grant is released on the current cycle.
   localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(MAX_BURST - 1);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_SRC - 1);

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   state_t               state_q, state_d;
   logic [NUM_SRC-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]     last_grant_q, last_grant_d;
   logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [7:0]           out_tdata_q, out_tdata_d;
   logic                 out_tvalid_q, out_tvalid_d;

   // --------------------------------------------------------------------------
   // Combinational helpers
   // --------------------------------------------------------------------------
   logic                 pick_found;
   logic [IDX_W-1:0]     pick_idx;
   logic [IDX_W-1:0]     cur_idx;
   logic [7:0]           cur_data;
   logic                 cur_valid;
   logic                 cur_last;
   logic                 out_free;
   logic                 accept;
   logic                 burst_done;
   logic                 stall_done;
   logic                 release_grant;

   // Round-robin search: start just above the last released source and wrap,
   // so the source that just finished is considered last.
   always_comb begin
      // NOTE: every variable written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      int            cand;
      logic [IDX_W-1:0] cand_idx;
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      cand_idx   = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand     = (int'(last_grant_q) + k) % NUM_SRC;
         cand_idx = IDX_W'(cand);
         if (!pick_found && in_tvalid[cand_idx]) begin
            pick_found = 1'b1;
            pick_idx   = cand_idx;
         end
      end
   end

   // Decode the one-hot grant into the granted source's index and stream.
   always_comb begin
      cur_idx  = '0;
      cur_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_q[i]) begin
            cur_idx  = IDX_W'(i);
            cur_data = in_tdata[8*i +: 8];
         end
      end
   end

   assign cur_valid = |(in_tvalid & grant_q);
   assign cur_last  = |(in_tlast & grant_q);

   // The output stage can take a byte when empty or when it drains this cycle.
   assign out_free   = ~out_tvalid_q | out_tready;
   assign accept     = (state_q == XFER) & cur_valid & out_free;
   assign burst_done = (beat_cnt_q == BEAT_LAST);

   // Only a granted source with tvalid low counts as stalled; a source held
   // off by output backpressure still has tvalid high and is not penalised.
   assign stall_done = (state_q == XFER) & ~cur_valid & (stall_cnt_q == STALL_LAST);

   assign release_grant = (accept & (cur_last | burst_done)) | stall_done;

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   // NOTE: asynchronous reset puts the arbiter back to IDLE at once, even
   // mid-packet; any byte in the output stage is discarded.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples the values from before this clock edge.
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------------------
   // FSM: next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = XFER;
            end
         end
         XFER: begin
            if (release_grant) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: outputs
   // --------------------------------------------------------------------------
   always_comb begin
      in_tready = '0;
      busy      = 1'b0;
      if (state_q == XFER) begin
         in_tready = grant_q & {NUM_SRC{out_free}};
         busy      = 1'b1;
      end
   end

   // --------------------------------------------------------------------------
   // Grant, counters and output stage: next values
   // --------------------------------------------------------------------------
   always_comb begin
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      stall_cnt_d  = stall_cnt_q;

      if (state_q == IDLE) begin
         if (pick_found) begin
            grant_d     = NUM_SRC'(1) << pick_idx;
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
         end
      end else begin
         if (release_grant) begin
            grant_d      = '0;
            last_grant_d = cur_idx;
            beat_cnt_d   = '0;
            stall_cnt_d  = '0;
         end else if (accept) begin
            beat_cnt_d  = beat_cnt_q + 1'b1;
            stall_cnt_d = '0;
         end else if (!cur_valid) begin
            // Cannot overflow: reaching STALL_LAST releases the grant above.
            stall_cnt_d = stall_cnt_q + 1'b1;
         end
      end
   end

   // A load takes priority over a drain, so a byte accepted in the same cycle
   // the previous one leaves keeps out_tvalid high with no bubble.
   always_comb begin
      out_tdata_d  = out_tdata_q;
      out_tvalid_d = out_tvalid_q;
      if (accept) begin
         out_tdata_d  = cur_data;
         out_tvalid_d = 1'b1;
      end else if (out_tready) begin
         out_tvalid_d = 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // Grant, counters and output stage: registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_q      <= '0;
         last_grant_q <= IDX_LAST;
         beat_cnt_q   <= '0;
         stall_cnt_q  <= '0;
         out_tdata_q  <= '0;
         out_tvalid_q <= 1'b0;
      end else begin
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
         out_tdata_q  <= out_tdata_d;
         out_tvalid_q <= out_tvalid_d;
      end
   end

   assign grant      = grant_q;
   assign out_tdata  = out_tdata_q;
   assign out_tvalid = out_tvalid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Testbench for uart_tx_arbiter (NUM_SRC=4, MAX_BURST=16, STALL_TIMEOUT=8).
// Per-source byte queues feed the DUT inputs; bytes expected at the output are
// pushed into a scoreboard queue in hand-derived arbitration order, and a
// monitor pops and compares on every output handshake. Grant timing is
// checked against hand-computed per-cycle traces and a log of grant starts.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int NUM_SRC = 4;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [8*NUM_SRC-1:0] in_tdata;
   logic [NUM_SRC-1:0]   in_tvalid;
   logic [NUM_SRC-1:0]   in_tlast;
   logic [NUM_SRC-1:0]   in_tready;
   logic [7:0]           out_tdata;
   logic                 out_tvalid;
   logic                 out_tready;
   logic [NUM_SRC-1:0]   grant;
   logic                 busy;

   uart_tx_arbiter #(
      .NUM_SRC       (NUM_SRC),
      .MAX_BURST     (16),
      .STALL_TIMEOUT (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .in_tdata   (in_tdata),
      .in_tvalid  (in_tvalid),
      .in_tlast   (in_tlast),
      .in_tready  (in_tready),
      .out_tdata  (out_tdata),
      .out_tvalid (out_tvalid),
      .out_tready (out_tready),
      .grant      (grant),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   logic [8:0]         src_q [NUM_SRC][$];   // {tlast, tdata}
   logic [7:0]         exp_q [$];
   logic [NUM_SRC-1:0] glog  [$];
   logic [NUM_SRC-1:0] prev_grant = '0;
   logic [NUM_SRC-1:0] hs;

   // Hand-derived per-cycle traces, one entry per falling edge.
   // t1: {busy, out_tvalid, grant}
   logic [5:0] t1_trace [6]  = '{6'b0_0_0000, 6'b1_0_0100, 6'b1_1_0100,
                                 6'b1_1_0100, 6'b0_1_0000, 6'b0_0_0000};
   logic [3:0] t2_trace [14] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0,
                                 4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0, 4'h0};
   logic [3:0] t5_trace [14] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8,
                                 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1, 4'h0};
   logic [3:0] t3_glog  [4]  = '{4'h2, 4'h1, 4'h2, 4'h2};
   logic [3:0] t6_glog  [2]  = '{4'h1, 4'h4};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_src(input int s, input logic [7:0] d, input logic l);
      src_q[s].push_back({l, d});
   endtask

   task automatic clear_queues();
      for (int i = 0; i < NUM_SRC; i++) src_q[i].delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset      = 1'b1;
      out_tready = 1'b1;
      clear_queues();
      #1;
      check("reset_outputs", {out_tvalid, out_tdata, grant, busy, in_tready}, '0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      glog.delete();
   endtask

   task automatic check_drained(input string name);
      check(name, exp_q.size(), 0);
   endtask

   // Source driver: handshakes are sampled on the falling edge (the values the
   // DUT sees at the next rising edge); the queue heads are re-driven just
   // after that rising edge.
   initial begin
      in_tvalid = '0;
      in_tlast  = '0;
      in_tdata  = '0;
      forever begin
         @(negedge clk);
         hs = in_tvalid & in_tready;
         @(posedge clk);
         #2;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!reset && hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         end
         for (int i = 0; i < NUM_SRC; i++) begin
            if (src_q[i].size() > 0) begin
               in_tvalid[i]       = 1'b1;
               in_tdata[8*i +: 8] = src_q[i][0][7:0];
               in_tlast[i]        = src_q[i][0][8];
            end else begin
               in_tvalid[i]       = 1'b0;
               in_tdata[8*i +: 8] = 8'h00;
               in_tlast[i]        = 1'b0;
            end
         end
      end
   end

   // Output monitor / scoreboard and grant-start log.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (!reset && out_tvalid && out_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", {24'h0, out_tdata}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("out_byte", {24'h0, out_tdata}, {24'h0, e});
            end
         end
         if (grant != '0 && prev_grant == '0) glog.push_back(grant);
         prev_grant = grant;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      out_tready = 1'b1;

      // ---- Single source: source 2 sends 41,42,43(last) ----
      do_reset();
      @(posedge clk); #1;
      push_src(2, 8'h41, 1'b0); push_src(2, 8'h42, 1'b0); push_src(2, 8'h43, 1'b1);
      exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("t1_trace_c%0d", k), {busy, out_tvalid, grant}, t1_trace[k]);
      end
      check_drained("t1_drained");

      // ---- Round robin: sources 0,1,3 each send two 1-byte packets ----
      do_reset();
      @(posedge clk); #1;
      push_src(0, 8'h10, 1'b1); push_src(0, 8'h11, 1'b1);
      push_src(1, 8'h20, 1'b1); push_src(1, 8'h21, 1'b1);
      push_src(3, 8'h30, 1'b1); push_src(3, 8'h31, 1'b1);
      exp_q.push_back(8'h10); exp_q.push_back(8'h20); exp_q.push_back(8'h30);
      exp_q.push_back(8'h11); exp_q.push_back(8'h21); exp_q.push_back(8'h31);
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         check($sformatf("t2_grant_c%0d", k), grant, t2_trace[k]);
      end
      check_drained("t2_drained");

      // ---- Burst cap: source 1 streams 40 bytes, source 0 cuts in ----
      do_reset();
      @(posedge clk); #1;
      for (int k = 0; k < 40; k++) push_src(1, 8'(8'h80 + k), 1'b0);
      for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h80 + k));
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      for (int k = 16; k < 40; k++) exp_q.push_back(8'(8'h80 + k));
      repeat (3) @(posedge clk);
      #1;
      push_src(0, 8'h01, 1'b0); push_src(0, 8'h02, 1'b1);
      repeat (100) @(negedge clk);
      check("t3_grant_count", glog.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (glog.size() > k) check($sformatf("t3_grant%0d", k), glog[k], t3_glog[k]);
      end
      check("t3_idle_after", {busy, grant}, '0);
      check_drained("t3_drained");

      // ---- Backpressure: out_tready low for 10 cycles mid-packet ----
      do_reset();
      @(posedge clk); #1;
      for (int k = 0; k < 6; k++) begin
         push_src(2, 8'(8'h51 + k), (k == 5));
         exp_q.push_back(8'(8'h51 + k));
      end
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      out_tready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check($sformatf("t4_hold_c%0d", k), {out_tvalid, out_tdata, in_tready, grant},
               {1'b1, 8'h52, 4'b0000, 4'b0100});
      end
      @(posedge clk); #1;
      out_tready = 1'b1;
      repeat (20) @(negedge clk);
      check_drained("t4_drained");

      // ---- Stall timeout: source 3 stops after 2 bytes, source 0 waits ----
      do_reset();
      @(posedge clk); #1;
      push_src(3, 8'h61, 1'b0); push_src(3, 8'h62, 1'b0);
      exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h07);
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         check($sformatf("t5_grant_c%0d", k), grant, t5_trace[k]);
         if (k == 2) push_src(0, 8'h07, 1'b1);
      end
      check_drained("t5_drained");

      // ---- Reset mid-packet while a byte is buffered ----
      do_reset();
      @(posedge clk); #1;
      out_tready = 1'b0;
      for (int k = 0; k < 8; k++) push_src(2, 8'(8'h71 + k), (k == 7));
      repeat (4) @(negedge clk);
      check("t6_pre_reset", {out_tvalid, out_tdata, grant}, {1'b1, 8'h71, 4'b0100});
      #1;
      reset = 1'b1;
      #1;
      check("t6_reset_now", {out_tvalid, out_tdata, grant, busy, in_tready}, '0);
      clear_queues();
      out_tready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      glog.delete();
      @(posedge clk); #1;
      push_src(0, 8'h0A, 1'b1); push_src(2, 8'h0B, 1'b1);
      exp_q.push_back(8'h0A); exp_q.push_back(8'h0B);
      repeat (12) @(negedge clk);
      check("t6_grant_count", glog.size(), 2);
      for (int k = 0; k < 2; k++) begin
         if (glog.size() > k) check($sformatf("t6_grant%0d", k), glog[k], t6_glog[k]);
      end
      check_drained("t6_drained");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
